bit_serializer: RTL

Parallel-to-serial stage that sits directly upstream of the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake. It shifts them out one bit per clock on `x`, which connects straight to the detector's `x` input. A one-word holding buffer lets consecutive words stream with no idle cycle between them.

---
 rtl/bit_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: valid/ready word intake,
// one-word holding buffer for gapless streaming, one bit per clock on x.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             x,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int unsigned     OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold_buf;
    logic [WIDTH-1:0] sreg;
    logic             buf_full;
    logic [CNT_W-1:0] cnt;

    logic             last_bit;
    logic             accept;
    logic             reload;
    logic             advance;

    assign last_bit = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (buf_full) state_d = SHIFT;
            SHIFT:   if (last_bit && !buf_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Output and datapath-control decode, purely from registers except the accept qualifier
    always_comb begin
        bit_valid  = 1'b0;
        word_done  = 1'b0;
        busy       = 1'b0;
        load_ready = 1'b0;
        x          = 1'b0;
        reload     = 1'b0;
        advance    = 1'b0;
        accept     = 1'b0;

        bit_valid  = (state_q == SHIFT);
        word_done  = bit_valid && last_bit;
        busy       = bit_valid || buf_full;
        load_ready = !buf_full;
        x          = bit_valid && sreg[OUT_IDX];
        reload     = buf_full && ((state_q == IDLE) || last_bit);
        advance    = (state_q == SHIFT) && !last_bit;
        accept     = load_valid && !buf_full;
    end

    // Holding buffer, shift register and bit counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_buf <= '0;
            buf_full <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
        end else if (abort) begin
            hold_buf <= '0;
            buf_full <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
        end else begin
            // accept and reload are exclusive: accept needs an empty buffer, reload a full one
            if (accept) begin
                hold_buf <= data_in;
                buf_full <= 1'b1;
            end else if (reload) begin
                buf_full <= 1'b0;
            end

            if (reload) begin
                sreg <= hold_buf;
                cnt  <= '0;
            end else if (advance) begin
                cnt <= cnt + CNT_W'(1);
                if (MSB_FIRST) begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end else begin
                    sreg <= {1'b0, sreg[WIDTH-1:1]};
                end
            end
        end
    end

endmodule
